infrarojo_tx: RTL and testbench

NEC-format infrared transmitter, the emitting end of the IR link whose receive side is the three-channel infrared front end. Accepts an 8-bit address and 8-bit command from the SoC side and serialises them as a carrier-modulated NEC frame: leader, 32 data bits, stop burst. Drives an IR LED through `salida`, and exposes the unmodulated envelope for loopback into a receiver channel.

---
 rtl/infrarojo_tx.sv | 159 +++++++++++++++
 tb/tb_infrarojo_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/infrarojo_tx.sv
// NEC-format infrared transmitter: leader, 32 data bits LSB first, stop burst.
// Registered envelope and carrier-modulated LED drive.
module infrarojo_tx #(
    parameter int UNIT_CYC     = 56250,
    parameter int CARRIER_HALF = 1316
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inicio,
    input  logic [7:0] direccion,
    input  logic [7:0] comando,
    output logic       listo,
    output logic       envolvente,
    output logic       salida,
    output logic       fin
);

    localparam int CW = $clog2(16 * UNIT_CYC);
    localparam int HW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

    localparam logic [CW-1:0] LAST_16 = CW'(16 * UNIT_CYC - 1);
    localparam logic [CW-1:0] LAST_8  = CW'(8 * UNIT_CYC - 1);
    localparam logic [CW-1:0] LAST_3  = CW'(3 * UNIT_CYC - 1);
    localparam logic [CW-1:0] LAST_1  = CW'(UNIT_CYC - 1);
    localparam logic [HW-1:0] CAR_LAST = HW'(CARRIER_HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;
    logic [31:0]   word_q, word_d;
    logic [HW-1:0] car_cnt_q, car_cnt_d;
    logic          car_q, car_d;
    logic          env_q, env_d;
    logic          sal_q, sal_d;
    logic          fin_q, fin_d;
    logic [CW-1:0] last_cnt;
    logic          phase_end;
    logic          mark_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            word_q    <= '0;
            car_cnt_q <= '0;
            car_q     <= 1'b0;
            env_q     <= 1'b0;
            sal_q     <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            word_q    <= word_d;
            car_cnt_q <= car_cnt_d;
            car_q     <= car_d;
            env_q     <= env_d;
            sal_q     <= sal_d;
            fin_q     <= fin_d;
        end
    end

    always_comb begin
        last_cnt = LAST_1;
        case (state_q)
            S_LEAD_MARK:  last_cnt = LAST_16;
            S_LEAD_SPACE: last_cnt = LAST_8;
            S_BIT_SPACE:  last_cnt = word_q[bit_q] ? LAST_3 : LAST_1;
            default:      last_cnt = LAST_1;
        endcase
    end

    assign phase_end = (cnt_q == last_cnt);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        word_d  = word_q;
        fin_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (inicio) begin
                    state_d = S_LEAD_MARK;
                    word_d  = {~comando, comando, ~direccion, direccion};
                end
            end
            S_LEAD_MARK: begin
                if (phase_end) state_d = S_LEAD_SPACE;
            end
            S_LEAD_SPACE: begin
                if (phase_end) begin
                    state_d = S_BIT_MARK;
                    bit_d   = '0;
                end
            end
            S_BIT_MARK: begin
                if (phase_end) state_d = S_BIT_SPACE;
            end
            S_BIT_SPACE: begin
                if (phase_end) begin
                    if (bit_q == 5'd31) begin
                        state_d = S_STOP_MARK;
                    end else begin
                        state_d = S_BIT_MARK;
                        bit_d   = bit_q + 5'd1;
                    end
                end
            end
            S_STOP_MARK: begin
                if (phase_end) begin
                    state_d = S_IDLE;
                    fin_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (phase_end && state_q != S_IDLE) cnt_d = '0;
    end

    // Carrier phase restarts high on the first cycle of every mark.
    always_comb begin
        env_d = (state_d == S_LEAD_MARK) || (state_d == S_BIT_MARK) ||
                (state_d == S_STOP_MARK);
        mark_start = env_d && (state_d != state_q);
        car_d     = car_q;
        car_cnt_d = car_cnt_q;
        if (!env_d) begin
            car_d     = 1'b0;
            car_cnt_d = '0;
        end else if (mark_start) begin
            car_d     = 1'b1;
            car_cnt_d = '0;
        end else if (car_cnt_q == CAR_LAST) begin
            car_d     = ~car_q;
            car_cnt_d = '0;
        end else begin
            car_cnt_d = car_cnt_q + 1'b1;
        end
        sal_d = env_d & car_d;
    end

    assign listo      = (state_q == S_IDLE);
    assign envolvente = env_q;
    assign salida     = sal_q;
    assign fin        = fin_q;

endmodule

// File: tb/tb_infrarojo_tx.sv
// Directed bench for infrarojo_tx with UNIT_CYC=8, CARRIER_HALF=2.
// Decodes transmitted frames from the envelope and checks carrier and timing.
module tb_infrarojo_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       inicio;
    logic [7:0] direccion;
    logic [7:0] comando;
    logic       listo;
    logic       envolvente;
    logic       salida;
    logic       fin;

    int checks   = 0;
    int failures = 0;
    int cycle_cnt = 0;

    infrarojo_tx #(
        .UNIT_CYC    (8),
        .CARRIER_HALF(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inicio    (inicio),
        .direccion (direccion),
        .comando   (comando),
        .listo     (listo),
        .envolvente(envolvente),
        .salida    (salida),
        .fin       (fin)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples one frame at negedges, starting at the first envelope-high cycle.
    task automatic run_frame(input bit poke, output logic [31:0] w,
                             output int len, output int lead_m,
                             output int lead_s, output int nmark,
                             output int bad, output int bad_car,
                             output int bad_listo);
        int   run;
        int   nspace;
        int   k;
        logic cur;
        w = '0; len = -1; lead_m = 0; lead_s = 0; nmark = 0;
        bad = 0; bad_car = 0; bad_listo = 0; nspace = 0;
        cur = 1'b1; run = 0; k = 0;
        while (envolvente !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (envolvente !== 1'b1) return;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (envolvente !== cur) begin
                if (cur) begin
                    if (nmark == 0) lead_m = run;
                    else if (run != 8) bad++;
                    nmark++;
                end else begin
                    if (nspace == 0) lead_s = run;
                    else if (nspace <= 32 && run == 24) w[nspace-1] = 1'b1;
                    else if (!(nspace <= 32 && run == 8)) bad++;
                    nspace++;
                end
                cur = envolvente;
                run = 0;
            end
            if (cur) begin
                if (salida !== (((run / 2) % 2) == 0)) bad_car++;
            end else if (salida !== 1'b0) begin
                bad_car++;
            end
            run++;
            if (fin === 1'b1) begin
                len = cyc;
                if (listo !== 1'b1) bad_listo++;
                break;
            end
            if (listo !== 1'b0) bad_listo++;
            if (poke) inicio = (cyc == 100 || cyc == 101 || cyc == 600);
            @(negedge clk);
        end
    endtask

    logic [31:0] w;
    int len, lead_m, lead_s, nmark, bad, bad_car, bad_listo;
    int t1, t2, stray;

    initial begin
        rst = 1'b1; inicio = 1'b1; direccion = 8'h00; comando = 8'h00;

        // Reset held with inicio asserted
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_listo", listo, 1);
            chk("rst_env", envolvente, 0);
            chk("rst_sal", salida, 0);
            chk("rst_fin", fin, 0);
        end
        rst = 1'b0; inicio = 1'b0;
        @(negedge clk);
        chk("post_rst_env", envolvente, 0);
        chk("post_rst_listo", listo, 1);

        // Frame 1: addr 0x00 cmd 0xFF
        inicio = 1'b1; direccion = 8'h00; comando = 8'hFF;
        @(negedge clk);
        inicio = 1'b0;
        chk("f1_listo_busy", listo, 0);
        run_frame(0, w, len, lead_m, lead_s, nmark, bad, bad_car, bad_listo);
        chk("f1_word", w, 32'h00FF_FF00);
        chk("f1_len", len, 968);
        chk("f1_lead_mark", lead_m, 128);
        chk("f1_lead_space", lead_s, 64);
        chk("f1_nmark", nmark, 34);
        chk("f1_bad_gaps", bad, 0);
        chk("f1_carrier", bad_car, 0);
        chk("f1_listo", bad_listo, 0);
        @(negedge clk);
        chk("f1_fin_pulse", fin, 0);
        chk("f1_idle_listo", listo, 1);

        // Frame 2: addr 0xA5 cmd 0x3C, stray inicio pulses mid-frame
        inicio = 1'b1; direccion = 8'hA5; comando = 8'h3C;
        @(negedge clk);
        inicio = 1'b0;
        run_frame(1, w, len, lead_m, lead_s, nmark, bad, bad_car, bad_listo);
        inicio = 1'b0;
        chk("f2_word", w, 32'hC33C_5AA5);
        chk("f2_len", len, 968);
        chk("f2_nmark", nmark, 34);
        chk("f2_bad_gaps", bad, 0);
        chk("f2_carrier", bad_car, 0);
        chk("f2_listo", bad_listo, 0);
        @(negedge clk);
        chk("f2_no_requeue_env", envolvente, 0);
        chk("f2_no_requeue_listo", listo, 1);

        // Back-to-back with inicio held high
        inicio = 1'b1; direccion = 8'h81; comando = 8'h7E;
        @(negedge clk);
        run_frame(0, w, len, lead_m, lead_s, nmark, bad, bad_car, bad_listo);
        t1 = cycle_cnt;
        chk("b2b_a_word", w, 32'h817E_7E81);
        chk("b2b_a_len", len, 968);
        @(negedge clk);
        chk("b2b_gap_env", envolvente, 1);
        chk("b2b_gap_fin", fin, 0);
        run_frame(0, w, len, lead_m, lead_s, nmark, bad, bad_car, bad_listo);
        t2 = cycle_cnt;
        inicio = 1'b0;
        chk("b2b_b_word", w, 32'h817E_7E81);
        chk("b2b_b_len", len, 968);
        chk("b2b_fin_spacing", t2 - t1, 969);
        chk("b2b_carrier", bad_car, 0);
        @(negedge clk);
        chk("b2b_end_env", envolvente, 0);

        // Reset 300 cycles into a frame
        inicio = 1'b1; direccion = 8'h12; comando = 8'h34;
        @(negedge clk);
        inicio = 1'b0;
        chk("abort_started", envolvente, 1);
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_env", envolvente, 0);
        chk("abort_sal", salida, 0);
        chk("abort_listo", listo, 1);
        chk("abort_fin", fin, 0);
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fin !== 1'b0 || envolvente !== 1'b0) stray++;
        end
        chk("abort_quiet", stray, 0);

        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        run_frame(0, w, len, lead_m, lead_s, nmark, bad, bad_car, bad_listo);
        chk("f3_word", w, 32'hCB34_ED12);
        chk("f3_len", len, 968);
        chk("f3_bad_gaps", bad, 0);
        chk("f3_carrier", bad_car, 0);
        chk("f3_listo", bad_listo, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
